// File: rtl/disparity_checker_rx.sv
// Receive-side 8b/10b running-disparity checker with saturating error count
// and a HUNT/LOCKED/CHECK link-lock state machine.
module disparity_checker_rx #(
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned ERR_LIMIT = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       sym_in,
  input  logic             sym_valid,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic             rd_out,
  output logic             disp_err,
  output logic             code_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             lock
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(ERR_LIMIT + 1);

  typedef enum logic [1:0] {HUNT, LOCKED, CHECK} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   good_cnt, good_nxt;
  logic [BW-1:0]   bad_cnt, bad_nxt;
  logic            rd_mid, rd_nxt;
  logic            d_err, c_err, sym_err;
  logic [2:0]      n6, n4;
  logic [CNT_W-1:0] err_cnt_nxt;
  logic            lock_nxt;

  function automatic logic [2:0] ones(input logic [5:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 6; i++) c = c + 3'(v[i]);
    return c;
  endfunction

  // Disparity/code check: 6b against current RD, 4b against RD after 6b.
  // rd_out encodes RD- as 1, RD+ as 0.
  always_comb begin
    n6     = ones(sym_in[9:4]);
    n4     = ones({2'b00, sym_in[3:0]});
    rd_mid = rd_out;
    rd_nxt = rd_out;
    d_err  = 1'b0;
    c_err  = 1'b0;
    case (n6)
      3'd3: if ((sym_in[9:4] == 6'b111000 && !rd_out) ||
                (sym_in[9:4] == 6'b000111 &&  rd_out)) d_err = 1'b1;
      3'd4: begin d_err = !rd_out; rd_mid = 1'b0; end
      3'd2: begin d_err =  rd_out; rd_mid = 1'b1; end
      default: c_err = 1'b1;
    endcase
    rd_nxt = rd_mid;
    case (n4)
      3'd2: if ((sym_in[3:0] == 4'b1100 && !rd_mid) ||
                (sym_in[3:0] == 4'b0011 &&  rd_mid)) d_err = 1'b1;
      3'd3: begin if (!rd_mid) d_err = 1'b1; rd_nxt = 1'b0; end
      3'd1: begin if ( rd_mid) d_err = 1'b1; rd_nxt = 1'b1; end
      default: c_err = 1'b1;
    endcase
    sym_err = d_err | c_err;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      bad_cnt  <= bad_nxt;
    end
  end

  // Next-state logic; only valid symbols advance the FSM
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    if (sym_valid) begin
      case (state)
        HUNT: begin
          if (sym_err) good_nxt = '0;
          else if (good_cnt + GW'(1) == GW'(LOCK_CNT)) begin
            state_nxt = LOCKED;
            good_nxt  = '0;
          end else good_nxt = good_cnt + GW'(1);
        end
        LOCKED: begin
          if (sym_err) begin
            state_nxt = CHECK;
            bad_nxt   = BW'(1);
            good_nxt  = '0;
          end
        end
        CHECK: begin
          if (sym_err) begin
            good_nxt = '0;
            if (bad_cnt + BW'(1) == BW'(ERR_LIMIT)) begin
              state_nxt = HUNT;
              bad_nxt   = '0;
            end else bad_nxt = bad_cnt + BW'(1);
          end else if (good_cnt + GW'(1) == GW'(LOCK_CNT)) begin
            state_nxt = LOCKED;
            good_nxt  = '0;
            bad_nxt   = '0;
          end else good_nxt = good_cnt + GW'(1);
        end
        default: begin
          state_nxt = HUNT;
          good_nxt  = '0;
          bad_nxt   = '0;
        end
      endcase
    end
  end

  // Output next values
  always_comb begin
    lock_nxt    = (state_nxt != HUNT);
    err_cnt_nxt = err_cnt;
    if (cnt_clr) err_cnt_nxt = (sym_valid && sym_err) ? CNT_W'(1) : '0;
    else if (sym_valid && sym_err && err_cnt != '1) err_cnt_nxt = err_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      rd_out    <= 1'b1;
      disp_err  <= 1'b0;
      code_err  <= 1'b0;
      err_cnt   <= '0;
      lock      <= 1'b0;
    end else begin
      out_valid <= sym_valid;
      disp_err  <= sym_valid & d_err;
      code_err  <= sym_valid & c_err;
      if (sym_valid) rd_out <= rd_nxt;
      err_cnt   <= err_cnt_nxt;
      lock      <= lock_nxt;
    end
  end

endmodule

// File: tb/tb_disparity_checker_rx.sv
// Directed and randomized checks of disparity_checker_rx against a
// running-disparity / lock reference model.
module tb_disparity_checker_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sym_in = '0;
  logic       sym_valid = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       out_valid, rd_out, disp_err, code_err, lock;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state: rdisp is the running disparity sign (-1 = RD-, +1 = RD+)
  int m_rd = -1;
  int m_err = 0;
  int m_st = 0;   // 0 hunt, 1 locked, 2 check
  int m_good = 0;
  int m_bad = 0;
  int e_ov = 0, e_de = 0, e_ce = 0;

  logic [9:0] tbl [0:7] = '{10'h274, 10'h18B, 10'h0FA, 10'h305,
                            10'h3FF, 10'h38B, 10'h1C4, 10'h2A5};

  disparity_checker_rx dut (
    .clk       (clk),
    .rst       (rst),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .cnt_clr   (cnt_clr),
    .out_valid (out_valid),
    .rd_out    (rd_out),
    .disp_err  (disp_err),
    .code_err  (code_err),
    .err_cnt   (err_cnt),
    .lock      (lock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [9:0] s, input logic v, input logic c, input logic r);
    int d6, d4;
    bit bad;
    logic [5:0] s6;
    logic [3:0] s4;
    if (r) begin
      m_rd = -1; m_err = 0; m_st = 0; m_good = 0; m_bad = 0;
      e_ov = 0; e_de = 0; e_ce = 0;
      return;
    end
    s6 = s[9:4];
    s4 = s[3:0];
    e_ov = v ? 1 : 0; e_de = 0; e_ce = 0;
    if (v) begin
      d6 = 2 * $countones(s6) - 6;
      if (d6 == 0) begin
        if ((s6 == 6'b111000 && m_rd > 0) || (s6 == 6'b000111 && m_rd < 0)) e_de = 1;
      end else if (d6 == 2 || d6 == -2) begin
        if (m_rd == d6 / 2) e_de = 1;
        m_rd = d6 / 2;
      end else e_ce = 1;
      d4 = 2 * $countones(s4) - 4;
      if (d4 == 0) begin
        if ((s4 == 4'b1100 && m_rd > 0) || (s4 == 4'b0011 && m_rd < 0)) e_de = 1;
      end else if (d4 == 2 || d4 == -2) begin
        if (m_rd == d4 / 2) e_de = 1;
        m_rd = d4 / 2;
      end else e_ce = 1;
    end
    bad = (e_de != 0) || (e_ce != 0);
    if (c) m_err = bad ? 1 : 0;
    else if (bad && m_err < 255) m_err++;
    if (v) begin
      case (m_st)
        0: if (bad) m_good = 0;
           else begin
             m_good++;
             if (m_good == 4) begin m_st = 1; m_good = 0; end
           end
        1: if (bad) begin m_st = 2; m_bad = 1; m_good = 0; end
        default: if (bad) begin
             m_good = 0; m_bad++;
             if (m_bad == 4) begin m_st = 0; m_bad = 0; end
           end else begin
             m_good++;
             if (m_good == 4) begin m_st = 1; m_good = 0; m_bad = 0; end
           end
      endcase
    end
  endtask

  task automatic step(input logic [9:0] s, input logic v, input logic c, input logic r,
                      input string tag);
    sym_in = s; sym_valid = v; cnt_clr = c; rst = r;
    model(s, v, c, r);
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({tag, ".rd_out"},    32'(rd_out),    (m_rd < 0) ? 32'd1 : 32'd0);
    chk({tag, ".disp_err"},  32'(disp_err),  32'(e_de));
    chk({tag, ".code_err"},  32'(code_err),  32'(e_ce));
    chk({tag, ".err_cnt"},   32'(err_cnt),   32'(m_err));
    chk({tag, ".lock"},      32'(lock),      (m_st != 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    // 1: reset state, then D.0.0 RD-
    step(10'h000, 1'b0, 1'b0, 1'b1, "reset");
    step(10'h274, 1'b1, 1'b0, 1'b0, "d00");
    // 2: K28.5 both polarities
    step(10'h0FA, 1'b1, 1'b0, 1'b0, "k285n");
    step(10'h305, 1'b1, 1'b0, 1'b0, "k285p");
    // 3: disparity violation from RD-
    step(10'h18B, 1'b1, 1'b0, 1'b0, "disp");
    step(10'h000, 1'b0, 1'b0, 1'b0, "idle");
    // 4: code violation, saturation, clear behaviour
    step(10'h3FF, 1'b1, 1'b0, 1'b0, "code");
    for (int i = 0; i < 260; i++) step(10'h3FF, 1'b1, 1'b0, 1'b0, "sat");
    step(10'h3FF, 1'b1, 1'b1, 1'b0, "clr_err");
    step(10'h000, 1'b0, 1'b1, 1'b0, "clr");
    // 5: lock sequence
    step(10'h000, 1'b0, 1'b0, 1'b1, "reset2");
    for (int i = 0; i < 4; i++) step(10'h274, 1'b1, 1'b0, 1'b0, "lock_in");
    step(10'h3FF, 1'b1, 1'b0, 1'b0, "check");
    for (int i = 0; i < 4; i++) step(10'h274, 1'b1, 1'b0, 1'b0, "relock");
    for (int i = 0; i < 4; i++) step(10'h3FF, 1'b1, 1'b0, 1'b0, "unlock");
    // 6: gapped stream with mid-stream reset
    for (int i = 0; i < 12; i++)
      step((i % 3 == 0) ? 10'h3FF : 10'h0FA, 1'(i % 2), 1'b0, 1'b0, "gap");
    step(10'h3FF, 1'b1, 1'b0, 1'b1, "rst_mid");
    step(10'h305, 1'b0, 1'b0, 1'b0, "gap_after");
    step(10'h305, 1'b1, 1'b0, 1'b0, "first_rdm");
    // Randomized mix of table and arbitrary symbols
    for (int i = 0; i < 400; i++) begin
      logic [9:0] s;
      s = ($urandom_range(0, 1) == 0) ? tbl[$urandom_range(0, 7)] : 10'($urandom);
      step(s, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 63) == 0), "rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
